pulse_spacer: RTL and testbench

PULSE_SPACER -- requirements
Module: pulse_spacer

---
 rtl/pulse_spacer_pkg.sv | 17 +
 rtl/pulse_spacer.sv | 102 ++++++++++
 tb/tb_pulse_spacer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_spacer_pkg.sv
// Shared types and defaults for the pulse spacer: FSM state encoding,
// default parameter values and the gap counter width.
package pulse_spacer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int DEF_MIN_GAP = 4;
    localparam int DEF_CNT_W   = 4;

    // Wide enough for the largest legal MIN_GAP (255).
    localparam int GAP_W = 8;

endpackage

// File: rtl/pulse_spacer.sv
// Turns a stream of single-cycle requests into output pulses spaced at least MIN_GAP low cycles apart.
// Optional sticky drop flag: define PULSE_SPACER_OVF_EN to add overflow_o / ovf_clr_i.
module pulse_spacer
    import pulse_spacer_pkg::*;
#(
    parameter int MIN_GAP = DEF_MIN_GAP,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             event_i,
`ifdef PULSE_SPACER_OVF_EN
    input  logic             ovf_clr_i,
    output logic             overflow_o,
`endif
    output logic             pulse_o,
    output logic [CNT_W-1:0] pending_o,
    output logic             busy_o
);

    state_e             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   pending_q, pending_d;
    logic               pulse_q, pulse_d;
    logic               have_req;
    logic               dec;
    logic               inc;
    logic               pend_max;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        gap_d     = gap_q;
        pending_d = pending_q;
        have_req  = event_i | (pending_q != '0);

        case (state_q)
            IDLE: begin
                if (have_req) state_d = PULSE;
            end
            PULSE: begin
                state_d = GAP;
                gap_d   = GAP_W'(MIN_GAP);
            end
            GAP: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q <= GAP_W'(1)) state_d = have_req ? PULSE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A pulse is issued on every entry to PULSE; it consumes one request.
        dec      = (state_d == PULSE);
        pend_max = (pending_q == '1);
        inc      = event_i & ~(pend_max & ~dec);

        if (inc & ~dec)      pending_d = pending_q + CNT_W'(1);
        else if (dec & ~inc) pending_d = pending_q - CNT_W'(1);

        pulse_d = dec;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state flops use non-blocking assignments so all registers update together.
        if (rst_i) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            pending_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            pending_q <= pending_d;
            pulse_q   <= pulse_d;
        end
    end

`ifdef PULSE_SPACER_OVF_EN
    logic overflow_q, overflow_d;
    logic drop;

    // Set beats clear when a drop and a clear land in the same cycle.
    always_comb begin
        drop       = event_i & pend_max & ~dec;
        overflow_d = overflow_q;
        if (drop)           overflow_d = 1'b1;
        else if (ovf_clr_i) overflow_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    assign overflow_o = overflow_q;
`endif

    assign pulse_o   = pulse_q;
    assign pending_o = pending_q;
    assign busy_o    = (state_q != IDLE) | (pending_q != '0);

endmodule

// File: tb/tb_pulse_spacer.sv
// Self-checking bench for pulse_spacer: directed scenarios plus random traffic
// compared every cycle against an arithmetic model of the spacing rules.
module tb_pulse_spacer;

    localparam int MIN_GAP = 4;
    localparam int CNT_W   = 4;
    localparam int MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             event_i;
    logic             pulse_o;
    logic [CNT_W-1:0] pending_o;
    logic             busy_o;
`ifdef PULSE_SPACER_OVF_EN
    logic             ovf_clr_i;
    logic             overflow_o;
    logic             exp_ovf;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc;
    int   m_last;
    int   exp_pending;
    int   accepted;
    int   pulses_seen;
    int   max_pend;
    int   density;
    logic exp_pulse;
    logic hit;

    pulse_spacer #(.MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .event_i   (event_i),
`ifdef PULSE_SPACER_OVF_EN
        .ovf_clr_i (ovf_clr_i),
        .overflow_o(overflow_o),
`endif
        .pulse_o   (pulse_o),
        .pending_o (pending_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A pulse may go out next cycle if any request is outstanding and the
    // previous pulse is more than MIN_GAP cycles back.
    function automatic logic pred_issue(input logic e);
        return (e || exp_pending > 0) && (cyc + 1 - m_last > MIN_GAP);
    endfunction

    task automatic cycle(input logic e, input logic r, input logic clr);
        logic issue;
        logic drop;
        int   n;
        event_i = e;
        rst_i   = r;
`ifdef PULSE_SPACER_OVF_EN
        ovf_clr_i = clr;
`endif
        if (r) begin
            exp_pulse   = 1'b0;
            exp_pending = 0;
            m_last      = -1000;
            accepted    = 0;
            pulses_seen = 0;
`ifdef PULSE_SPACER_OVF_EN
            exp_ovf     = 1'b0;
`endif
        end else begin
            issue = pred_issue(e);
            n     = exp_pending + int'(e) - int'(issue);
            drop  = (n > MAX);
            if (drop) n = MAX;
            if (e && !drop) accepted++;
            if (issue) m_last = cyc + 1;
            exp_pulse   = issue;
            exp_pending = n;
`ifdef PULSE_SPACER_OVF_EN
            if (drop)     exp_ovf = 1'b1;
            else if (clr) exp_ovf = 1'b0;
`else
            if (clr && drop) n = n;
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pulse_o === 1'b1) pulses_seen++;
        if (int'(pending_o) > max_pend) max_pend = int'(pending_o);
        check("pulse", pulse_o, exp_pulse);
        check("pending", pending_o, exp_pending);
        check("busy", busy_o, ((cyc - m_last) <= MIN_GAP) || (exp_pending != 0));
`ifdef PULSE_SPACER_OVF_EN
        check("overflow", overflow_o, exp_ovf);
`endif
    endtask

    initial begin
        rst_i       = 1'b1;
        event_i     = 1'b0;
`ifdef PULSE_SPACER_OVF_EN
        ovf_clr_i   = 1'b0;
        exp_ovf     = 1'b0;
`endif
        cyc         = 0;
        m_last      = -1000;
        exp_pending = 0;
        exp_pulse   = 1'b0;
        accepted    = 0;
        pulses_seen = 0;
        max_pend    = 0;
        density     = 50;
        repeat (2) @(posedge clk);

        // Reset state, with a request that must be ignored.
        cycle(1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // Single event: pulse next cycle, busy for MIN_GAP+1 cycles.
        cycle(1'b1, 1'b0, 1'b0);
        check("single_pulse", pulse_o, 1);
        check("single_pend", pending_o, 0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        check("single_busy_last", busy_o, 1);
        cycle(1'b0, 1'b0, 1'b0);
        check("single_idle", busy_o, 0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // Burst of three: pulses at +1, +6, +11.
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        check("burst_pend2", pending_o, 2);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        check("burst_pulse2", pulse_o, 1);
        check("burst_pend1", pending_o, 1);
        repeat (5) cycle(1'b0, 1'b0, 1'b0);
        check("burst_pulse3", pulse_o, 1);
        check("burst_pend0", pending_o, 0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // Saturation with requests held high for 40 cycles.
        max_pend = 0;
        repeat (40) cycle(1'b1, 1'b0, 1'b0);
        check("sat_max", max_pend, MAX);
        check("sat_pend", pending_o, MAX);
`ifdef PULSE_SPACER_OVF_EN
        check("sat_ovf", overflow_o, 1);
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!pred_issue(1'b1) && exp_pending == MAX) begin
                cycle(1'b1, 1'b0, 1'b1);
                check("ovf_collide", overflow_o, 1);
                hit = 1'b1;
                break;
            end
            cycle(1'b1, 1'b0, 1'b0);
        end
        check("ovf_collide_reached", hit, 1);
        cycle(1'b0, 1'b0, 1'b1);
        check("ovf_clear", overflow_o, 0);
`endif

        // Request on a pulse-issuing cycle at full count is accepted.
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pred_issue(1'b1) && exp_pending == MAX) begin
                cycle(1'b1, 1'b0, 1'b0);
                check("sat_dec_pend", pending_o, MAX);
`ifdef PULSE_SPACER_OVF_EN
                check("sat_dec_ovf", overflow_o, 0);
`endif
                hit = 1'b1;
                break;
            end
            cycle(exp_pending != MAX, 1'b0, 1'b0);
        end
        check("sat_dec_reached", hit, 1);

        repeat (100) cycle(1'b0, 1'b0, 1'b0);
        check("drain_count", pulses_seen, accepted);
        check("drain_idle", busy_o, 0);

        // Reset in the middle of a backlog while in the gap.
        hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (exp_pending == 5 && (cyc - m_last) >= 1 && (cyc - m_last) <= MIN_GAP) begin
                hit = 1'b1;
                break;
            end
            cycle(1'b1, 1'b0, 1'b0);
        end
        check("rst_backlog_reached", hit, 1);
        cycle(1'b0, 1'b1, 1'b0);
        check("rst_pulse", pulse_o, 0);
        check("rst_pend", pending_o, 0);
`ifdef PULSE_SPACER_OVF_EN
        check("rst_ovf", overflow_o, 0);
`endif
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        check("rst_no_pulse", pulses_seen, 0);

        // Random traffic with varying density, occasional reset and clear.
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) density = int'($urandom_range(10, 95));
            cycle(int'($urandom_range(0, 99)) < density,
                  $urandom_range(0, 99) == 0,
                  $urandom_range(0, 15) == 0);
        end
        repeat (100) cycle(1'b0, 1'b0, 1'b0);
        check("rand_count", pulses_seen, accepted);
        check("rand_idle", busy_o, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
